// File: rtl/display_pkg.sv
// display_pkg: shared widths, colour constant and FSM state type for the
// scrolling background renderer.
//   DefColW/DefRowW - screen column/row and image width/height bits
//   DefAddrW        - pixel ROM address bits
//   DefDataW        - pixel bits (RGB444)
//   DefMemLat       - ROM read latency in cycles
package display_pkg;

  localparam int unsigned DefColW   = 10;
  localparam int unsigned DefRowW   = 9;
  localparam int unsigned DefAddrW  = 19;
  localparam int unsigned DefDataW  = 12;
  localparam int unsigned DefMemLat = 1;

  localparam logic [11:0] Black = 12'h000;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPreload = 2'd1,
    StActive  = 2'd2
  } state_e;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: loadable up-counter that wraps to zero when it reaches a limit.
//   i_clk, i_rst_n - clock, async active-low reset
//   i_load         - load i_load_val (has priority over i_inc)
//   i_inc          - advance by one, wrapping to 0 at i_limit
//   i_limit        - wrap point (value never reaches it)
//   o_value        - registered count
//   o_next         - value after this cycle's load/inc (combinational)
//   o_wrap         - pulse: this cycle's increment wraps
module wrap_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_value,
  output logic [W-1:0] o_next,
  output logic         o_wrap
);

  logic [W-1:0] r_value;
  logic [W:0]   w_plus1;

  always_comb begin
    w_plus1 = {1'b0, r_value} + 1'b1;
    o_wrap  = 1'b0;
    o_next  = r_value;
    if (i_load) begin
      o_next = i_load_val;
    end else if (i_inc) begin
      // >= rather than == so a value that is already out of range still recovers
      if (w_plus1 >= {1'b0, i_limit}) begin
        o_wrap = 1'b1;
        o_next = '0;
      end else begin
        o_next = w_plus1[W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_value <= '0;
    else          r_value <= o_next;
  end

  assign o_value = r_value;

endmodule

// File: rtl/display_bg_scroll.sv
// display_bg_scroll: scrolling, tiling background renderer between the VGA
// timing generator and the layer mixer. Maps screen pixels onto a tiled image
// in an external synchronous pixel ROM using wrap counters (no divide/multiply).
//   i_clk, i_rst_n   - pixel clock, async active-low reset
//   i_en             - layer enable (0 renders black, valid unaffected)
//   i_frame_start    - vblank pulse; latches width/height/scroll/base
//   i_pix_valid      - visible pixel at i_col/i_row this cycle
//   i_col, i_row     - screen position (col 0 starts a line; row unused)
//   i_width/height   - image size; i_scroll_x/y offsets; i_base_addr ROM base
//   o_mem_addr       - registered ROM address; i_mem_data returns MEM_LAT later
//   o_vga_data/valid - pixel out, MEM_LAT+2 cycles after i_pix_valid
//   o_cfg_err        - sticky: bad configuration seen at a frame_start
//   o_underrun       - sticky: pixel arrived before line_base preload finished
module display_bg_scroll
  import display_pkg::*;
#(
  parameter int unsigned COL_W   = DefColW,
  parameter int unsigned ROW_W   = DefRowW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned MEM_LAT = DefMemLat
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_frame_start,
  input  logic              i_pix_valid,
  input  logic [COL_W-1:0]  i_col,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [COL_W-1:0]  i_width,
  input  logic [ROW_W-1:0]  i_height,
  input  logic [COL_W-1:0]  i_scroll_x,
  input  logic [ROW_W-1:0]  i_scroll_y,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [DATA_W-1:0] o_vga_data,
  output logic              o_vga_valid,
  output logic              o_cfg_err,
  output logic              o_underrun
);

  state_e              r_state, w_state_d;
  logic [COL_W-1:0]    r_w, r_sx, w_sx_eff;
  logic [ROW_W-1:0]    r_h, r_sy, w_sy_eff, r_cnt, w_cnt_d;
  logic [ADDR_W-1:0]   r_base, r_line_base, w_lb_pre, w_line_base_d, w_w_ext;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_d;
  logic                r_first_line, w_first_d, w_line_step, w_addr_upd;
  logic                w_dims_ok, w_sx_bad, w_sy_bad, w_black;
  logic                w_relx_load, w_relx_inc, w_rely_load, w_rely_inc, w_rely_wrap;
  logic                w_relx_wrap_unused;
  logic [ROW_W-1:0]    w_rely_val, w_rely, w_rely_next;
  logic [COL_W-1:0]    w_relx, w_relx_next;
  logic [MEM_LAT:0]    r_vld_pipe, r_blk_pipe;
  logic [DATA_W-1:0]   r_vga_data;
  logic                r_vga_valid, r_cfg_err, r_underrun;
  logic                w_unused;

  assign w_unused = ^{i_row, w_rely, w_rely_next, w_relx, w_relx_wrap_unused};

  // Configuration checks on the raw inputs; offsets out of range fall back to 0
  assign w_dims_ok = (i_width != '0) && (i_height != '0);
  assign w_sx_bad  = (i_scroll_x >= i_width);
  assign w_sy_bad  = (i_scroll_y >= i_height);
  assign w_sx_eff  = w_sx_bad ? '0 : i_scroll_x;
  assign w_sy_eff  = w_sy_bad ? '0 : i_scroll_y;
  assign w_w_ext   = ADDR_W'(r_w);

  // A pixel coinciding with frame_start is treated as a PRELOAD pixel
  assign w_black = !i_en || i_frame_start || (r_state != StActive);

  wrap_counter #(.W(COL_W)) u_relx (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_relx_load),
    .i_load_val (r_sx),
    .i_inc      (w_relx_inc),
    .i_limit    (r_w),
    .o_value    (w_relx),
    .o_next     (w_relx_next),
    .o_wrap     (w_relx_wrap_unused)
  );

  wrap_counter #(.W(ROW_W)) u_rely (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_rely_load),
    .i_load_val (w_rely_val),
    .i_inc      (w_rely_inc),
    .i_limit    (r_h),
    .o_value    (w_rely),
    .o_next     (w_rely_next),
    .o_wrap     (w_rely_wrap)
  );

  // FSM and counter control
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_lb_pre    = r_line_base;
    w_line_step = 1'b0;
    w_first_d   = r_first_line;
    w_relx_load = 1'b0;
    w_relx_inc  = 1'b0;
    w_rely_load = 1'b0;
    w_rely_val  = r_sy;
    w_rely_inc  = 1'b0;
    w_addr_upd  = 1'b0;
    if (i_frame_start) begin
      w_cnt_d  = '0;
      w_lb_pre = '0;
      if (!w_dims_ok) begin
        w_state_d = StIdle;
      end else if (w_sy_eff == '0) begin
        // Nothing to preload: go straight to rendering
        w_state_d   = StActive;
        w_rely_load = 1'b1;
        w_rely_val  = '0;
        w_first_d   = 1'b1;
      end else begin
        w_state_d = StPreload;
      end
    end else begin
      case (r_state)
        StPreload: begin
          // line_base = sy * w by one add per cycle
          w_cnt_d  = r_cnt + 1'b1;
          w_lb_pre = r_line_base + w_w_ext;
          if (w_cnt_d == r_sy) begin
            w_state_d   = StActive;
            w_rely_load = 1'b1;
            w_first_d   = 1'b1;
          end
        end
        StActive: begin
          if (i_pix_valid) begin
            w_addr_upd = 1'b1;
            if (i_col == '0) begin
              w_relx_load = 1'b1;
              if (r_first_line) begin
                w_first_d = 1'b0;
              end else begin
                w_rely_inc  = 1'b1;
                w_line_step = 1'b1;
              end
            end else begin
              w_relx_inc = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Separate block so the rely wrap (which depends on w_rely_inc) feeds forward only
  always_comb begin
    w_line_base_d = w_lb_pre;
    if (w_line_step) w_line_base_d = w_rely_wrap ? '0 : r_line_base + w_w_ext;
    w_mem_addr_d = r_base + w_line_base_d + ADDR_W'(w_relx_next);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_line_base  <= '0;
      r_first_line <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_line_base  <= w_line_base_d;
      r_first_line <= w_first_d;
      if (w_addr_upd) r_mem_addr <= w_mem_addr_d;
    end
  end

  // Shadow configuration and sticky flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_w        <= '0;
      r_h        <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_base     <= '0;
      r_cfg_err  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (i_frame_start) begin
        r_w    <= i_width;
        r_h    <= i_height;
        r_sx   <= w_sx_eff;
        r_sy   <= w_sy_eff;
        r_base <= i_base_addr;
        if (!w_dims_ok || w_sx_bad || w_sy_bad) r_cfg_err <= 1'b1;
      end
      if (i_pix_valid && (i_frame_start || r_state == StPreload)) r_underrun <= 1'b1;
    end
  end

  // Valid/black flags travel alongside the ROM read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe  <= '0;
      r_blk_pipe  <= '0;
      r_vga_valid <= 1'b0;
      r_vga_data  <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[MEM_LAT-1:0], i_pix_valid};
      r_blk_pipe  <= {r_blk_pipe[MEM_LAT-1:0], w_black};
      r_vga_valid <= r_vld_pipe[MEM_LAT];
      r_vga_data  <= (r_vld_pipe[MEM_LAT] && !r_blk_pipe[MEM_LAT]) ? i_mem_data
                                                                   : DATA_W'(Black);
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_vga_data  = r_vga_data;
  assign o_vga_valid = r_vga_valid;
  assign o_cfg_err   = r_cfg_err;
  assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_display_bg_scroll.sv
// Directed bench for display_bg_scroll with a 1-cycle synchronous ROM model.
module tb_display_bg_scroll;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  col = '0;
  logic [8:0]  row = '0;
  logic [9:0]  width = '0;
  logic [8:0]  height = '0;
  logic [9:0]  scroll_x = '0;
  logic [8:0]  scroll_y = '0;
  logic [18:0] base_addr = '0;
  logic [18:0] mem_addr;
  logic [11:0] mem_data = '0;
  logic [11:0] vga_data;
  logic        vga_valid;
  logic        cfg_err;
  logic        underrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected vga outputs, indexed by edges since the pixel was sampled
  logic        pv[3];
  logic [11:0] pd[3];

  display_bg_scroll #(.MEM_LAT(1)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_frame_start (frame_start),
    .i_pix_valid   (pix_valid),
    .i_col         (col),
    .i_row         (row),
    .i_width       (width),
    .i_height      (height),
    .i_scroll_x    (scroll_x),
    .i_scroll_y    (scroll_y),
    .i_base_addr   (base_addr),
    .o_mem_addr    (mem_addr),
    .i_mem_data    (mem_data),
    .o_vga_data    (vga_data),
    .o_vga_valid   (vga_valid),
    .o_cfg_err     (cfg_err),
    .o_underrun    (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom(input logic [18:0] a);
    return a[11:0] ^ 12'h5A5;
  endfunction

  always @(posedge clk) mem_data <= rom(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ev, input logic [11:0] ed);
    @(posedge clk);
    #1;
    pv[2] = pv[1]; pd[2] = pd[1];
    pv[1] = pv[0]; pd[1] = pd[0];
    pv[0] = ev;    pd[0] = ed;
    chk("vga_valid", {31'd0, vga_valid}, {31'd0, pv[2]});
    chk("vga_data", {20'd0, vga_data}, {20'd0, pd[2]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h000);
  endtask

  // One pixel; blk selects black output, ca enables the address check
  task automatic px(input logic [9:0] c, input logic blk, input logic ca,
                    input logic [18:0] ea);
    pix_valid = 1'b1;
    col = c;
    step(1'b1, blk ? 12'h000 : rom(ea));
    if (ca) chk("mem_addr", {13'd0, mem_addr}, {13'd0, ea});
    pix_valid = 1'b0;
  endtask

  task automatic fs(input logic [9:0] w, input logic [8:0] h, input logic [9:0] sx,
                    input logic [8:0] sy, input logic [18:0] b, input logic pix);
    width = w; height = h; scroll_x = sx; scroll_y = sy; base_addr = b;
    frame_start = 1'b1;
    pix_valid = pix;
    col = '0;
    step(pix, 12'h000);
    frame_start = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pd[i] = 12'h000;
    end
    chk("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
    chk("rst_vga_valid", {31'd0, vga_valid}, 32'd0);
    chk("rst_vga_data", {20'd0, vga_data}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int t2[13] = '{90, 91, 92, 93, 94, 95, 96, 97, 98, 99, 0, 1, 2};

  initial begin
    do_reset();

    // 1: plain 640x480, no scroll
    fs(10'd640, 9'd480, 10'd0, 9'd0, 19'd0, 1'b0);
    for (int i = 0; i <= 5; i++) px(10'(i), 1'b0, 1'b1, 19'(i));
    idle(3);
    chk("t1_cfg_err", {31'd0, cfg_err}, 32'd0);

    // 2: horizontal scroll with column wrap
    fs(10'd100, 9'd50, 10'd90, 9'd0, 19'd0, 1'b0);
    for (int i = 0; i < 13; i++) px(10'(i), 1'b0, 1'b1, 19'(t2[i]));
    idle(4);
    px(10'd0, 1'b0, 1'b1, 19'd190);
    px(10'd1, 1'b0, 1'b1, 19'd191);
    idle(3);

    // 3: vertical scroll at the last row, then row wrap
    fs(10'd100, 9'd50, 10'd0, 9'd49, 19'd1000, 1'b0);
    idle(49);
    px(10'd0, 1'b0, 1'b1, 19'd5900);
    px(10'd1, 1'b0, 1'b1, 19'd5901);
    idle(2);
    px(10'd0, 1'b0, 1'b1, 19'd1000);
    px(10'd1, 1'b0, 1'b1, 19'd1001);
    idle(2);
    px(10'd0, 1'b0, 1'b1, 19'd1100);
    idle(3);
    chk("t3_underrun", {31'd0, underrun}, 32'd0);

    // 4: pixels during PRELOAD are black and flag underrun
    fs(10'd100, 9'd50, 10'd0, 9'd20, 19'd0, 1'b0);
    idle(4);
    px(10'd0, 1'b1, 1'b0, 19'd0);
    chk("t4_underrun", {31'd0, underrun}, 32'd1);
    idle(14);
    px(10'd0, 1'b1, 1'b0, 19'd0);
    px(10'd0, 1'b0, 1'b1, 19'd2000);
    px(10'd1, 1'b0, 1'b1, 19'd2001);
    idle(3);

    // 5: zero width -> IDLE, black; next good frame renders, cfg_err sticky
    fs(10'd0, 9'd50, 10'd0, 9'd0, 19'd0, 1'b0);
    chk("t5_cfg_err", {31'd0, cfg_err}, 32'd1);
    px(10'd0, 1'b1, 1'b0, 19'd0);
    px(10'd1, 1'b1, 1'b0, 19'd0);
    idle(3);
    fs(10'd100, 9'd50, 10'd10, 9'd0, 19'd0, 1'b0);
    px(10'd0, 1'b0, 1'b1, 19'd10);
    idle(3);
    chk("t5_cfg_sticky", {31'd0, cfg_err}, 32'd1);

    // 5b: scroll_x >= width clamps to 0; pixel alongside frame_start is black
    do_reset();
    fs(10'd100, 9'd50, 10'd150, 9'd0, 19'd0, 1'b1);
    chk("t5b_cfg_err", {31'd0, cfg_err}, 32'd1);
    chk("t5b_underrun", {31'd0, underrun}, 32'd1);
    px(10'd0, 1'b0, 1'b1, 19'd0);
    px(10'd1, 1'b0, 1'b1, 19'd1);
    idle(3);

    // 6: en toggle mid-line, then async reset mid-line
    do_reset();
    fs(10'd100, 9'd50, 10'd0, 9'd0, 19'd0, 1'b0);
    px(10'd0, 1'b0, 1'b1, 19'd0);
    en = 1'b0;
    px(10'd1, 1'b1, 1'b1, 19'd1);
    en = 1'b1;
    px(10'd2, 1'b0, 1'b1, 19'd2);
    px(10'd3, 1'b0, 1'b1, 19'd3);
    px(10'd4, 1'b0, 1'b1, 19'd4);
    pix_valid = 1'b1;
    col = 10'd5;
    do_reset();
    pix_valid = 1'b0;
    idle(4);
    chk("t6_mem_addr", {13'd0, mem_addr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
